pp_uart_rx_fifo: RTL and testbench
==================================

# pp_uart_rx_fifo

Parametrised second-generation UART receiver with an integrated receive FIFO. It takes an oversampled serial line and supports 5–8 data bits, none/odd/even parity and 1 or 2 stop bits. It detects parity errors, framing errors, break conditions and overruns, and tags each received word with its own error flags. It sits between the UART pin and the peripheral bus register file, and replaces the single-word receiver so the CPU can read in bursts.

## Interface
Parameters:
- OSR, 16: oversample ticks per bit; even, 8..32.
- DEPTH, 8: FIFO entries; power of two, 2..64.
- AW, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- soft_rst  in  1  synchronous reset, active-low; same effect as rst.
- uart_clk  in  1  oversample tick enable, OSR pulses per bit time.
- uart_dataH  in  1  serial input, idle high.
- rx_en  in  1  receiver enable.
- data_flag  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- check_flag  in  2  parity: 00 none, 01 odd, 10 even, 11 none.
- stop_flag  in  1  0 = one stop bit, 1 = two stop bits.
- rd_en  in  1  pop the head entry.
- err_clr  in  1  clear sticky overrun.
- rx_data  out  8  head-entry data, zero-extended above the frame width.
- rx_parity_err  out  1  head-entry parity error.
- rx_frame_err  out  1  head-entry framing error.
- rx_break  out  1  head-entry break flag.
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- rx_count  out  AW+1  entries held, 0..DEPTH.
- overrun  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- Input synchroniser: two flops, both reset to 1. The FSM sees only the synchronised value.
- The FSM and tick counter advance only on cycles where uart_clk=1; all other cycles hold state.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT.
- IDLE:
  - If rx_en=1 and line=0 on a tick: tick counter cleared; data_flag, check_flag and stop_flag latched; go to START.
  - If rx_en=0: no start detection.
- START: at tick OSR/2-1 after detection (bit centre), sample the line.
  - 1: false start, return to IDLE; nothing pushed.
  - 0: go to DATA; counter reset.
- DATA: sample every OSR ticks, LSB first, N = 5+data_flag bits. Then go to PARITY if parity is enabled, else STOP1.
- PARITY: one sample.
  - Odd mode: error if XOR(data, parity bit) != 1.
  - Even mode: error if XOR(data, parity bit) != 0.
- STOP1: sample the line; 0 sets frame_err. If stop_flag=1, go to STOP2, else finish.
- STOP2: sample the line; 0 sets frame_err; finish.
- Break: all data bits, the parity bit (if present) and every sampled stop bit are 0. Sets the break flag and frame_err.
- Finish:
  - Push {break, frame_err, parity_err, data} on the final stop-sample cycle.
  - Next state is BRKWAIT if break, else IDLE.
- BRKWAIT: stay until a tick sees line=1, then go to IDLE.
- rx_en falling mid-frame: the current frame completes and is pushed.
- Config inputs changing mid-frame have no effect until the next start.
- FIFO behaviour:
  - First-word fall-through: the head entry is visible whenever rx_empty=0.
  - rd_en while empty is ignored.
  - Push while full, without a same-cycle pop: word dropped, overrun set.
  - Push and pop in the same cycle while full: both happen, rx_count unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only.
- overrun is cleared by err_clr. If err_clr and a new overrun occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH. rx_count is a separate (AW+1)-bit counter.

## Timing
- Reset (rst or soft_rst): state IDLE, FIFO emptied.
  - Outputs: rx_data=0, all rx_* flags 0, rx_empty=1, rx_full=0, rx_count=0, overrun=0.
  - Reset asserted mid-frame discards the partial frame.
- Push to visibility: rx_empty falls and rx_count increments on the clock edge after the push cycle.
- Pop: the head entry advances on the clock edge after the rd_en cycle.
- Frame length from start detection to push: OSR/2 + (N + P + S)·OSR ticks, where P = parity bits, S = stop bits. Pin-to-detect adds 2 clk of synchroniser latency.
- rx_full = (rx_count == DEPTH); rx_empty = (rx_count == 0). Both are registered, not combinational from pointers.

## Test plan
- 8N1, OSR=16, byte 0xA5: after one frame, rx_data=0xA5, all error flags 0, rx_count=1. rd_en → rx_empty=1.
- 7E2 with a wrong parity bit on 0x35: rx_data=0x35, rx_parity_err=1. Then 5O1 0x1F with correct parity: flags 0, rx_data=0x1F.
- 8N1, stop bit driven 0 on 0x3C: rx_frame_err=1, rx_break=0. Then line held low for 2 frame times: one entry with rx_break=1, data 0x00, and no further push until the line returns high.
- Glitch: line low for OSR/4 ticks only → no push, FSM back in IDLE.
- DEPTH=8: nine frames with no reads → rx_full=1, rx_count=8, overrun=1, and entries 0–7 intact. err_clr → overrun=0. Push coinciding with rd_en while full → rx_count stays 8, overrun stays 0.
- soft_rst=0 mid-DATA with 3 entries queued → rx_count=0, rx_empty=1. The next clean frame is received correctly.

Source files
------------

// File: rtl/pp_uart_rx_fifo.sv
// pp_uart_rx_fifo: oversampled UART receiver (5-8 data bits, parity, 1/2 stop) feeding a first-word-fall-through FIFO
module pp_uart_rx_fifo #(
  parameter int OSR = 16,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soft_rst,
  input  logic          uart_clk,
  input  logic          uart_dataH,
  input  logic          rx_en,
  input  logic [1:0]    data_flag,
  input  logic [1:0]    check_flag,
  input  logic          stop_flag,
  input  logic          rd_en,
  input  logic          err_clr,
  output logic [7:0]    rx_data,
  output logic          rx_parity_err,
  output logic          rx_frame_err,
  output logic          rx_break,
  output logic          rx_empty,
  output logic          rx_full,
  output logic [AW:0]   rx_count,
  output logic          overrun
);
  localparam int CW = $clog2(OSR);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;
  state_t state;
  logic s1, line;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx, last_bit;
  logic [1:0] par_mode;
  logic two_stop, par_acc, perr, ferr, nz;
  logic [7:0] shreg;
  logic [10:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count, count_n;
  logic par_en, push, pop, wr;
  logic [10:0] word;
  always_comb begin
    par_en = ^par_mode;
    push = uart_clk && cnt == CW'(OSR-1) && (state == STOP2 || (state == STOP1 && !two_stop));
    // nz tracks whether any sampled bit of the frame was 1; all-zero means break
    word = {~(nz | line), ferr | ~line, perr, shreg};
    pop = rd_en && !rx_empty;
    wr = push && (!rx_full || pop);
    count_n = count + (AW+1)'(wr) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b1;
      line <= 1'b1;
      state <= IDLE;
      {cnt, bit_idx, last_bit, par_mode, two_stop, shreg, par_acc, perr, ferr, nz} <= '0;
    end else if (!soft_rst) begin
      s1 <= 1'b1;
      line <= 1'b1;
      state <= IDLE;
      {cnt, bit_idx, last_bit, par_mode, two_stop, shreg, par_acc, perr, ferr, nz} <= '0;
    end else begin
      s1 <= uart_dataH;
      line <= s1;
      if (uart_clk)
        case (state)
          IDLE: if (rx_en && !line) begin
            state <= START;
            cnt <= '0;
            last_bit <= 3'd4 + {1'b0, data_flag};
            par_mode <= check_flag;
            two_stop <= stop_flag;
            {bit_idx, shreg, par_acc, perr, ferr, nz} <= '0;
          end
          START: if (cnt == CW'(OSR/2-1)) begin
            cnt <= '0;
            state <= line ? IDLE : DATA;
          end else cnt <= cnt + CW'(1);
          BRKWAIT: if (line) state <= IDLE;
          default: if (cnt != CW'(OSR-1)) cnt <= cnt + CW'(1);
          else begin
            cnt <= '0;
            nz <= nz | line;
            case (state)
              DATA: begin
                shreg[bit_idx] <= line;
                par_acc <= par_acc ^ line;
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == last_bit) state <= par_en ? PARITY : STOP1;
              end
              PARITY: begin
                perr <= par_mode[0] ? ~(par_acc ^ line) : (par_acc ^ line);
                state <= STOP1;
              end
              STOP1: begin
                ferr <= ~line;
                state <= two_stop ? STOP2 : (nz | line) ? IDLE : BRKWAIT;
              end
              default: state <= (nz | line) ? IDLE : BRKWAIT;
            endcase
          end
        endcase
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= word;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {wp, rp, count, rx_full, overrun} <= '0;
      rx_empty <= 1'b1;
    end else if (!soft_rst) begin
      {wp, rp, count, rx_full, overrun} <= '0;
      rx_empty <= 1'b1;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count_n;
      rx_empty <= count_n == '0;
      rx_full <= count_n == (AW+1)'(DEPTH);
      overrun <= (push && rx_full && !pop) || (overrun && !err_clr);
    end
  assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = rx_empty ? '0 : mem[rp];
  assign rx_count = count;
endmodule

// File: tb/tb_pp_uart_rx_fifo.sv
// tb_pp_uart_rx_fifo: random and directed frames against a queue-based receiver/FIFO model
module tb_pp_uart_rx_fifo;
  localparam int OSR = 16, DEPTH = 8, AW = 3;
  logic clk = 0, rst, soft_rst, uart_clk, uart_dataH, rx_en, rd_en, err_clr, stop_flag;
  logic [1:0] data_flag, check_flag;
  logic [7:0] rx_data;
  logic rx_parity_err, rx_frame_err, rx_break, rx_empty, rx_full, overrun;
  logic [AW:0] rx_count;
  int n_cmp = 0, n_bad = 0, tick_now = 0, rd_pm = 0, clr_pm = 0;
  bit chk_on = 0, rd_auto = 0, pop_at_push = 0, ovr = 0;
  typedef struct {int t; logic [10:0] w;} pend_t;
  pend_t pend[$];
  logic [10:0] q[$];

  pp_uart_rx_fifo #(.OSR(OSR), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .uart_clk(uart_clk), .uart_dataH(uart_dataH),
    .rx_en(rx_en), .data_flag(data_flag), .check_flag(check_flag), .stop_flag(stop_flag),
    .rd_en(rd_en), .err_clr(err_clr), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_break(rx_break), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_count(rx_count), .overrun(overrun));

  initial forever #5 clk = ~clk;
  initial begin
    uart_clk = 0;
    forever begin
      @(negedge clk);
      uart_clk = ~uart_clk;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: each frame's word lands in the queue on the tick the frame-length rule predicts
  always @(posedge clk or negedge rst) begin
    logic push, pop, full;
    pend_t p;
    if (!rst) begin
      q.delete();
      pend.delete();
      ovr = 0;
    end else begin
      if (uart_clk) tick_now++;
      if (!soft_rst) begin
        q.delete();
        pend.delete();
        ovr = 0;
      end else begin
        push = uart_clk && pend.size() > 0 && pend[0].t == tick_now;
        pop = rd_en && q.size() > 0;
        full = q.size() == DEPTH;
        if (push) p = pend.pop_front();
        if (pop) void'(q.pop_front());
        if (push && (!full || pop)) q.push_back(p.w);
        ovr = (push && full && !pop) || (ovr && !err_clr);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      chk("count", 32'(rx_count), 32'(q.size()));
      chk("empty", 32'(rx_empty), 32'(q.size() == 0));
      chk("full", 32'(rx_full), 32'(q.size() == DEPTH));
      chk("overrun", 32'(overrun), 32'(ovr));
      if (q.size() > 0) chk("head", 32'({rx_break, rx_frame_err, rx_parity_err, rx_data}), 32'(q[0]));
    end
  end

  initial begin
    rd_en = 0;
    err_clr = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rd_auto) begin
        rd_en = int'($urandom_range(0, 999)) < rd_pm;
        err_clr = int'($urandom_range(0, 999)) < clr_pm;
      end else if (pop_at_push) rd_en = uart_clk && pend.size() > 0 && pend[0].t == tick_now + 1;
    end
  end

  task automatic tick_align();
    do begin
      @(negedge clk);
      #1;
    end while (!uart_clk);
  endtask

  task automatic hold(input int n);
    repeat (n) tick_align();
  endtask

  task automatic pop1();
    @(negedge clk);
    #1 rd_en = 1;
    @(negedge clk);
    #1 rd_en = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] df, input logic [1:0] cf, input logic sf,
                            input logic bad_par, input logic s1v, input logic s2v, input int extra_low);
    int n;
    logic [7:0] dm;
    logic pen, pbit, perr, ferr, brk;
    n = 5 + int'(df);
    dm = d & 8'(8'hFF >> (2'd3 - df));
    pen = cf == 2'b01 || cf == 2'b10;
    pbit = (cf == 2'b01 ? ~^dm : ^dm) ^ bad_par;
    perr = pen && bad_par;
    brk = dm == 8'h00 && (!pen || !pbit) && !s1v && (!sf || !s2v);
    ferr = !s1v || (sf && !s2v) || brk;
    tick_align();
    rx_en = 1;
    data_flag = df;
    check_flag = cf;
    stop_flag = sf;
    pend.push_back('{tick_now + 2 + OSR/2 + (n + int'(pen) + 1 + int'(sf)) * OSR, {brk, ferr, perr, dm}});
    uart_dataH = 0;
    hold(OSR);
    {data_flag, check_flag, stop_flag} = 5'($urandom);
    rx_en = $urandom_range(0, 3) != 0;
    for (int i = 0; i < n; i++) begin
      uart_dataH = dm[i];
      hold(OSR);
    end
    if (pen) begin
      uart_dataH = pbit;
      hold(OSR);
    end
    uart_dataH = s1v;
    hold(OSR);
    if (sf) begin
      uart_dataH = s2v;
      hold(OSR);
    end
    if (extra_low > 0) begin
      uart_dataH = 0;
      hold(extra_low);
    end
    uart_dataH = 1;
    rx_en = 1;
    hold(OSR + int'($urandom_range(0, OSR)));
  endtask

  task automatic rand_batch(input int nf, input int pm, input int cpm);
    rd_pm = pm;
    clr_pm = cpm;
    rd_auto = 1;
    repeat (nf)
      send_frame(8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) != 0, $urandom_range(0, 6) != 0, 0);
    @(negedge clk);
    #1 rd_auto = 0;
    rd_en = 0;
    err_clr = 0;
  endtask

  initial begin
    logic [7:0] dd [10];
    rst = 0;
    soft_rst = 1;
    uart_dataH = 1;
    rx_en = 1;
    data_flag = 2'b11;
    check_flag = 2'b00;
    stop_flag = 0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(rx_data), 32'h0);
    chk("rst_flags", 32'({rx_parity_err, rx_frame_err, rx_break}), 32'h0);
    chk("rst_empty", 32'(rx_empty), 32'h1);
    chk("rst_full", 32'(rx_full), 32'h0);
    chk("rst_count", 32'(rx_count), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    #1 rst = 1;
    chk_on = 1;
    send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_flags", 32'({rx_parity_err, rx_frame_err, rx_break}), 32'h0);
    chk("a5_count", 32'(rx_count), 32'h1);
    pop1();
    chk("a5_pop_empty", 32'(rx_empty), 32'h1);
    send_frame(8'h35, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    chk("7e2_data", 32'(rx_data), 32'h35);
    chk("7e2_perr", 32'(rx_parity_err), 32'h1);
    pop1();
    send_frame(8'h1F, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("5o1_data", 32'(rx_data), 32'h1F);
    chk("5o1_flags", 32'({rx_parity_err, rx_frame_err, rx_break}), 32'h0);
    pop1();
    send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("fe_data", 32'(rx_data), 32'h3C);
    chk("fe_ferr", 32'(rx_frame_err), 32'h1);
    chk("fe_brk", 32'(rx_break), 32'h0);
    pop1();
    send_frame(8'h00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 20 * OSR);
    chk("brk_count", 32'(rx_count), 32'h1);
    chk("brk_flags", 32'({rx_break, rx_frame_err}), 32'h3);
    chk("brk_data", 32'(rx_data), 32'h0);
    pop1();
    tick_align();
    uart_dataH = 0;
    hold(OSR / 4);
    uart_dataH = 1;
    hold(3 * OSR);
    chk("glitch_count", 32'(rx_count), 32'h0);
    rx_en = 0;
    tick_align();
    uart_dataH = 0;
    hold(2 * OSR);
    uart_dataH = 1;
    hold(2 * OSR);
    rx_en = 1;
    chk("rxen_off_count", 32'(rx_count), 32'h0);
    for (int i = 0; i < 9; i++) begin
      dd[i] = 8'(i * 37 + 5);
      send_frame(dd[i], 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    end
    chk("ovr_full", 32'(rx_full), 32'h1);
    chk("ovr_count", 32'(rx_count), 32'h8);
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_head", 32'(rx_data), 32'h05);
    @(negedge clk);
    #1 err_clr = 1;
    @(negedge clk);
    #1 err_clr = 0;
    chk("ovr_clr", 32'(overrun), 32'h0);
    dd[9] = 8'hC3;
    pop_at_push = 1;
    send_frame(dd[9], 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    pop_at_push = 0;
    rd_en = 0;
    chk("pp_count", 32'(rx_count), 32'h8);
    chk("pp_overrun", 32'(overrun), 32'h0);
    for (int i = 1; i < 10; i++)
      if (i != 8) begin
        chk("ovr_entry", 32'(rx_data), 32'(dd[i]));
        pop1();
      end
    chk("ovr_drained", 32'(rx_empty), 32'h1);
    for (int i = 0; i < 3; i++) send_frame(8'(8'h60 + i), 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("srst_pre_count", 32'(rx_count), 32'h3);
    tick_align();
    uart_dataH = 0;
    hold(OSR);
    uart_dataH = 1;
    hold(3 * OSR);
    @(negedge clk);
    #1 soft_rst = 0;
    @(negedge clk);
    #1 soft_rst = 1;
    hold(8 * OSR);
    chk("srst_count", 32'(rx_count), 32'h0);
    chk("srst_empty", 32'(rx_empty), 32'h1);
    send_frame(8'h5A, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("srst_next_data", 32'(rx_data), 32'h5A);
    chk("srst_next_count", 32'(rx_count), 32'h1);
    pop1();
    rand_batch(20, 3, 0);
    rand_batch(12, 0, 2);
    rand_batch(20, 20, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
